// File: rtl/segment_transition_ctrl.sv
// Playback-segment controller: owns the active segment's sample index and loop
// counter, and switches segments under SYNC_IDX, SYS_TIME, GPIO and EXT modes.
module segment_transition_ctrl #(
   parameter int NUM_SEGMENT = 2,
   parameter int IDX_WIDTH   = 16,
   parameter int REP_WIDTH   = 16,
   parameter int NUM_GPIO    = 4,
   parameter int SEG_W       = $clog2(NUM_SEGMENT)
) (
   input  logic                             CLK,
   input  logic                             RESET_N,
   input  logic                             UPDATE,
   input  logic [SEG_W-1:0]                 REQ_SEGMENT,
   input  logic [7:0]                       TRANSITION_MODE,
   input  logic [63:0]                      TRANSITION_VALUE,
   input  logic [NUM_SEGMENT*IDX_WIDTH-1:0] CYCLE,
   input  logic [NUM_SEGMENT*REP_WIDTH-1:0] REP,
   input  logic                             STEP,
   input  logic [63:0]                      SYS_TIME,
   input  logic [NUM_GPIO-1:0]              GPIO_IN,
   output logic [SEG_W-1:0]                 SEGMENT,
   output logic [IDX_WIDTH-1:0]             IDX,
   output logic                             PENDING,
   output logic                             STOP,
   output logic                             SWITCHED
);

   localparam int GPIO_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
   localparam logic [7:0] M_SYNC = 8'h00;
   localparam logic [7:0] M_TIME = 8'h01;
   localparam logic [7:0] M_GPIO = 8'h02;
   localparam logic [7:0] M_EXT  = 8'hF0;

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_HOLD} state_t;

   state_t                 state_q;
   logic [SEG_W-1:0]       seg_q;
   logic [IDX_WIDTH-1:0]   idx_q;
   logic [REP_WIDTH-1:0]   loop_q;
   logic                   pending_q;
   logic                   stop_q;
   logic                   switched_q;
   logic                   auto_q;
   logic [NUM_GPIO-1:0]    gpio_prev_q;
   logic [SEG_W-1:0]       req_seg_q;
   logic [7:0]             mode_q;
   logic [63:0]            value_q;

   logic [IDX_WIDTH-1:0]   cyc_d;
   logic [REP_WIDTH-1:0]   rep_d;
   logic [SEG_W-1:0]       seg_next_d;
   logic [GPIO_W-1:0]      gsel_d;
   logic                   at_end_d;
   logic                   exhaust_d;
   logic                   mode_ok_d;
   logic                   upd_ok_d;
   logic                   cond_d;
   logic                   req_fire_d;
   logic                   auto_fire_d;

   always_comb begin
      cyc_d      = CYCLE[seg_q*IDX_WIDTH +: IDX_WIDTH];
      rep_d      = REP[seg_q*REP_WIDTH +: REP_WIDTH];
      seg_next_d = (seg_q == SEG_W'(NUM_SEGMENT-1)) ? '0 : seg_q + 1'b1;
      gsel_d     = value_q[GPIO_W-1:0];
      at_end_d   = (idx_q >= cyc_d);
      exhaust_d  = (loop_q == rep_d) && (rep_d != {REP_WIDTH{1'b1}});
      mode_ok_d  = (TRANSITION_MODE == M_SYNC) || (TRANSITION_MODE == M_TIME) ||
                   (TRANSITION_MODE == M_GPIO) || (TRANSITION_MODE == M_EXT);
      upd_ok_d   = UPDATE && mode_ok_d &&
                   ({1'b0, REQ_SEGMENT} < (SEG_W+1)'(NUM_SEGMENT));
      cond_d     = 1'b0;
      case (mode_q)
         M_SYNC, M_EXT: cond_d = STEP && ((state_q == S_HOLD) || at_end_d);
         M_TIME:        cond_d = (SYS_TIME >= value_q);
         M_GPIO:        cond_d = GPIO_IN[gsel_d] && !gpio_prev_q[gsel_d];
         default:       cond_d = 1'b0;
      endcase
      // A fresh UPDATE replaces the pending request, so the old one cannot fire.
      req_fire_d  = pending_q && cond_d && !upd_ok_d;
      auto_fire_d = auto_q && STEP && (state_q != S_HOLD) && at_end_d &&
                    exhaust_d && !req_fire_d;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_RUN;
         seg_q       <= '0;
         idx_q       <= '0;
         loop_q      <= '0;
         pending_q   <= 1'b0;
         stop_q      <= 1'b0;
         switched_q  <= 1'b0;
         auto_q      <= 1'b0;
         gpio_prev_q <= '0;
         req_seg_q   <= '0;
         mode_q      <= '0;
         value_q     <= '0;
      end else begin
         switched_q  <= 1'b0;
         gpio_prev_q <= GPIO_IN;
         if (req_fire_d || auto_fire_d) begin
            seg_q      <= req_fire_d ? req_seg_q : seg_next_d;
            idx_q      <= '0;
            loop_q     <= '0;
            stop_q     <= 1'b0;
            pending_q  <= 1'b0;
            switched_q <= 1'b1;
            state_q    <= S_RUN;
            if (req_fire_d) auto_q <= (mode_q == M_EXT);
         end else begin
            if (upd_ok_d) begin
               req_seg_q <= REQ_SEGMENT;
               mode_q    <= TRANSITION_MODE;
               value_q   <= TRANSITION_VALUE;
               pending_q <= 1'b1;
               if (state_q != S_HOLD) state_q <= S_WAIT;
            end
            // HOLD keeps any pending request; the index stays parked at the last sample.
            if ((state_q != S_HOLD) && STEP) begin
               if (at_end_d) begin
                  if (exhaust_d) begin
                     state_q <= S_HOLD;
                     stop_q  <= 1'b1;
                  end else begin
                     idx_q  <= '0;
                     loop_q <= loop_q + 1'b1;
                  end
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
         end
      end
   end

   assign SEGMENT  = seg_q;
   assign IDX      = idx_q;
   assign PENDING  = pending_q;
   assign STOP     = stop_q;
   assign SWITCHED = switched_q;

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// Directed bench for segment_transition_ctrl with hand-computed expectations.
module tb_segment_transition_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        update = 1'b0;
   logic [0:0]  req_seg = '0;
   logic [7:0]  mode = '0;
   logic [63:0] value = '0;
   logic [31:0] cycle_v = '0;
   logic [31:0] rep_v = '0;
   logic        step = 1'b0;
   logic [63:0] sys_time = '0;
   logic [3:0]  gpio = '0;
   logic [0:0]  segment;
   logic [15:0] idx;
   logic        pending, stop, switched;

   int checks = 0;
   int errors = 0;

   segment_transition_ctrl dut (
      .CLK(clk), .RESET_N(rst_n), .UPDATE(update), .REQ_SEGMENT(req_seg),
      .TRANSITION_MODE(mode), .TRANSITION_VALUE(value), .CYCLE(cycle_v),
      .REP(rep_v), .STEP(step), .SYS_TIME(sys_time), .GPIO_IN(gpio),
      .SEGMENT(segment), .IDX(idx), .PENDING(pending), .STOP(stop),
      .SWITCHED(switched)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_seg", segment, 0);
      chk("rst_idx", idx, 0);
      chk("rst_pend", pending, 0);
      chk("rst_stop", stop, 0);
      chk("rst_sw", switched, 0);
      tick();
      rst_n = 1'b1;
   endtask

   task automatic req(input logic [0:0] s, input logic [7:0] m, input logic [63:0] v);
      update = 1'b1; req_seg = s; mode = m; value = v;
      tick();
      update = 1'b0;
   endtask

   int exp_idx[5]  = '{1, 0, 1, 1, 1};
   int exp_stp[5]  = '{0, 0, 0, 1, 1};
   int e_seg[6]    = '{0, 1, 1, 0, 0, 1};
   int e_idx[6]    = '{1, 0, 1, 0, 1, 0};
   int e_sw[6]     = '{0, 1, 0, 1, 0, 1};
   int h_seg[5]    = '{1, 0, 0, 0, 0};
   int h_idx[5]    = '{1, 0, 1, 1, 1};
   int h_stp[5]    = '{0, 0, 0, 1, 1};

   initial begin
      #1;
      // free-running wrap with infinite repeat
      cycle_v = {16'd5, 16'd3};
      rep_v   = {16'hFFFF, 16'hFFFF};
      do_reset();
      step = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("wrap_idx", idx, (i + 1) % 4);
         chk("wrap_seg", segment, 0);
         chk("wrap_stop", stop, 0);
      end
      step = 1'b0;

      // finite repeat exhaustion
      cycle_v = {16'd5, 16'd1};
      rep_v   = {16'hFFFF, 16'd1};
      do_reset();
      step = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_idx", idx, exp_idx[i]);
         chk("hold_stop", stop, exp_stp[i]);
      end
      step = 1'b0;
      req(0, 8'h05, 0);
      chk("bad_mode_pend", pending, 0);

      // SYNC_IDX switch at wrap
      cycle_v = {16'd5, 16'd3};
      rep_v   = {16'hFFFF, 16'hFFFF};
      do_reset();
      step = 1'b1; tick(); step = 1'b0;
      req(1, 8'h00, 0);
      chk("sync_pend", pending, 1);
      chk("sync_idx1", idx, 1);
      step = 1'b1;
      tick(); chk("sync_idx2", idx, 2); chk("sync_seg2", segment, 0);
      tick(); chk("sync_idx3", idx, 3); chk("sync_seg3", segment, 0);
      tick(); chk("sync_seg", segment, 1); chk("sync_idx0", idx, 0);
      chk("sync_sw", switched, 1); chk("sync_pend0", pending, 0);
      step = 1'b0;
      tick(); chk("sync_sw_off", switched, 0);

      // SYS_TIME crossing
      sys_time = 64'd990;
      req(0, 8'h01, 64'd1000);
      for (int t = 991; t <= 1001; t++) begin
         sys_time = 64'(t);
         tick();
         chk("time_seg", segment, (t >= 1000) ? 0 : 1);
         chk("time_sw", switched, (t == 1000) ? 1 : 0);
      end
      req(1, 8'h01, 64'd500);
      chk("past_pend", pending, 1);
      chk("past_seg_n1", segment, 0);
      tick();
      chk("past_seg_n2", segment, 1);
      chk("past_sw", switched, 1);
      chk("past_pend0", pending, 0);

      // GPIO rising edge
      gpio = 4'b0100;
      req(0, 8'h02, 64'd2);
      tick(); tick();
      chk("gpio_held_seg", segment, 1);
      gpio = 4'b0110; tick();
      gpio = 4'b0100; tick();
      chk("gpio_other_seg", segment, 1);
      chk("gpio_other_pend", pending, 1);
      gpio = 4'b0000; tick();
      chk("gpio_low_seg", segment, 1);
      gpio = 4'b0100; tick();
      chk("gpio_edge_seg", segment, 0);
      chk("gpio_edge_sw", switched, 1);
      gpio = 4'b0000; tick();

      // EXT auto-advance, then SYNC_IDX clears auto and the segment halts
      cycle_v = {16'd1, 16'd1};
      rep_v   = {16'd0, 16'd0};
      req(1, 8'hF0, 0);
      chk("ext_pend", pending, 1);
      step = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("ext_seg", segment, e_seg[i]);
         chk("ext_idx", idx, e_idx[i]);
         chk("ext_sw", switched, e_sw[i]);
      end
      step = 1'b0;
      req(0, 8'h00, 0);
      chk("halt_pend", pending, 1);
      step = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("halt_seg", segment, h_seg[i]);
         chk("halt_idx", idx, h_idx[i]);
         chk("halt_stop", stop, h_stp[i]);
      end
      step = 1'b0;

      // asynchronous reset mid-cycle drops the pending request
      req(1, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("pre_rst_pend", pending, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_pend", pending, 0);
      chk("async_stop", stop, 0);
      chk("async_idx", idx, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_pend", pending, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/segment_transition_ctrl.md
# segment_transition_ctrl

Parametrised playback-segment controller for the modulation and STM engines. It generalises the fixed two-segment double-buffer to NUM_SEGMENT segments. It owns the sample index and loop counter of the active segment, and performs segment switches under the four transition modes (SYNC_IDX, SYS_TIME, GPIO, EXT). It sits between the controller register file (request fields, per-segment cycle and repeat) and the memory read path that consumes SEGMENT/IDX.

## Interface
Parameters:
- NUM_SEGMENT, 2, number of segments (≥2)
- IDX_WIDTH, 16, index width; max cycle 2^IDX_WIDTH
- REP_WIDTH, 16, repeat field width; all-ones = infinite
- NUM_GPIO, 4, GPIO trigger inputs
- SEG_W, $clog2(NUM_SEGMENT), derived

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- UPDATE  in  1  one-cycle pulse: latch REQ_SEGMENT/TRANSITION_MODE/TRANSITION_VALUE
- REQ_SEGMENT  in  SEG_W  requested segment
- TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT
- TRANSITION_VALUE  in  64  mode argument (time or GPIO number)
- CYCLE  in  NUM_SEGMENT*IDX_WIDTH  per-segment last index (cycle−1), segment s at [s*IDX_WIDTH +: IDX_WIDTH]
- REP  in  NUM_SEGMENT*REP_WIDTH  per-segment repeat count R (plays R+1 loops)
- STEP  in  1  advance-index pulse from frequency divider
- SYS_TIME  in  64  system time
- GPIO_IN  in  NUM_GPIO  synchronised trigger inputs
- SEGMENT  out  SEG_W  active segment
- IDX  out  IDX_WIDTH  current index
- PENDING  out  1  request latched, not yet applied
- STOP  out  1  finite repeat exhausted, index held
- SWITCHED  out  1  one-cycle pulse on segment switch

## Operation
- States: RUN, WAIT (pending request), HOLD (exhausted). Reset: RUN, SEGMENT=0, IDX=0, PENDING=0, STOP=0, SWITCHED=0, loop counter=0, auto flag=0, GPIO edge register=0.
- STEP in RUN/WAIT: IDX+1; if IDX ≥ CYCLE[SEGMENT] (CYCLE sampled live), IDX←0 (wrap) and loop counter+1.
- Exhaustion: wrap with loop counter == REP[SEGMENT] and REP ≠ all-ones. If auto=0: go to HOLD, IDX stays at CYCLE[SEGMENT], STOP=1, STEPs ignored. If auto=1: switch to (SEGMENT+1) mod NUM_SEGMENT as a SYNC_IDX switch.
- UPDATE with a valid mode and REQ_SEGMENT < NUM_SEGMENT: latch the fields, go to WAIT, PENDING=1. Otherwise ignored. UPDATE in WAIT replaces the pending request. UPDATE in HOLD is accepted.
- Switch conditions, evaluated in WAIT:
  - SYNC_IDX / EXT: the STEP that wraps. In HOLD, the next STEP.
  - SYS_TIME: SYS_TIME ≥ TRANSITION_VALUE (unsigned).
  - GPIO: rising edge on GPIO_IN[TRANSITION_VALUE[$clog2(NUM_GPIO)-1:0]]. Edge = current high, previous low; previous is registered every cycle.
- On switch: SEGMENT←request, IDX←0, loop counter←0, STOP←0, PENDING←0, SWITCHED=1 for one cycle, state RUN.
- Auto flag: EXT sets auto=1 at the switch; any non-EXT switch clears it.
- A switch to the current segment is a restart (index and loop counter reset).

## Timing
- UPDATE sampled at edge N; PENDING=1 from N+1. The condition is evaluated in cycles ≥ N+1. A condition true in cycle k gives SEGMENT/IDX updated, SWITCHED=1 and PENDING=0 in cycle k+1.
- A SYS_TIME already past gives a switch visible at N+2.
- A GPIO edge in the UPDATE cycle itself is not counted.
- Switch and STEP in the same cycle: the switch wins and IDX=0. The step is consumed (it is the trigger for SYNC_IDX/EXT, otherwise dropped).
- SYNC_IDX wrap that coincides with exhaustion: the switch wins; no HOLD, STOP stays 0.
- RESET_N low at any time forces reset values asynchronously and drops the pending request.

## Test plan
- Reset, CYCLE[0]=3, REP[0]=all-ones, 10 STEPs → IDX 1,2,3,0,1,2,3,0,1,2. SEGMENT=0, STOP=0 throughout.
- REP[0]=1, CYCLE[0]=1, 5 STEPs → IDX 1,0,1 then HOLD at 1 with STOP=1. Further STEPs leave IDX=1.
- UPDATE SYNC_IDX to seg 1 at IDX=1 of CYCLE[0]=3 → PENDING=1. The two STEPs to IDX 2,3 keep seg 0. The wrap STEP gives SEGMENT=1, IDX=0, SWITCHED one cycle.
- UPDATE SYS_TIME, value=1000, SYS_TIME=990 counting +1/cycle → switch visible the cycle after SYS_TIME=1000. Value=500 → switch at UPDATE+2.
- UPDATE GPIO, value=2 (NUM_GPIO=4). Pulse GPIO_IN[1] → no switch. Hold GPIO_IN[2] high across UPDATE → no switch. Low-then-high → switch one cycle after the edge.
- EXT to seg 1 with REP[1]=0, CYCLE[1]=1, REP[0]=0, CYCLE[0]=1 → sequence seg1 idx0,1 → seg0 idx0,1 → seg1 … with SWITCHED at each change. A later SYNC_IDX UPDATE clears auto and the segment then halts at STOP.
